spiker_sample_ctrl: RTL and testbench
=====================================

SPIKER_SAMPLE_CTRL -- requirements
Module: spiker_sample_ctrl

Interface
REQ-001 SHALL have parameter N_STEPS_W, default 16: width of the time-step count.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048575: maximum WAIT cycles per step before error.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  in  1  one-cycle run request from the register file.
REQ-006 SHALL have port abort_i  in  1  cancel the run in progress.
REQ-007 SHALL have port clear_i  in  1  acknowledge completion; returns the block to IDLE.
REQ-008 SHALL have port n_steps_i  in  N_STEPS_W  number of core time steps per run.
REQ-009 SHALL have port core_ready_i  in  1  core accepts a step start.
REQ-010 SHALL have port core_done_i  in  1  core finished the current step (one-cycle pulse).
REQ-011 SHALL have port core_start_o  out  1  step start request (valid) to the core.
REQ-012 SHALL have port sample_o  out  1  one-cycle strobe to the spike-result writer.
REQ-013 SHALL have port busy_o  out  1  run in progress.
REQ-014 SHALL have port done_o  out  1  sticky completion flag.
REQ-015 SHALL have port err_o  out  1  sticky timeout flag.
REQ-016 SHALL have port irq_o  out  1  one-cycle interrupt pulse on entry to DONE.
REQ-017 SHALL have port step_cnt_o  out  N_STEPS_W  number of completed steps in the current run.

Function
REQ-018 SHALL implement the states IDLE, STEP, WAIT, SAMPLE and DONE.
REQ-019 IDLE: on start_i with n_steps_i != 0, SHALL latch n_steps_i, clear step_cnt_o, err_o and done_o, and go to STEP.
REQ-020 IDLE: on start_i with n_steps_i == 0, SHALL go directly to DONE with no core_start_o and no sample_o.
REQ-021 STEP: SHALL hold core_start_o high; when core_ready_i is high in the same cycle, SHALL go to WAIT and clear the timeout counter.
REQ-022 WAIT: SHALL increment the timeout counter every cycle.
REQ-023 WAIT, on core_done_i: SHALL increment step_cnt_o; if the new count equals the latched n_steps, SHALL go to SAMPLE, otherwise SHALL go to STEP.
REQ-024 WAIT: when the timeout counter reaches TIMEOUT_CYCLES without core_done_i, SHALL set err_o and go to DONE without asserting sample_o.
REQ-025 If core_done_i and the timeout occur in the same cycle, core_done_i SHALL win.
REQ-026 SAMPLE: SHALL assert sample_o for exactly one cycle, then go to DONE.
REQ-027 DONE: SHALL hold done_o high and pulse irq_o for one cycle on the entry cycle.
REQ-028 DONE: SHALL stay in DONE until clear_i, then go to IDLE; clear_i SHALL NOT clear err_o (only the next start clears it).
REQ-029 abort_i in STEP, WAIT or SAMPLE SHALL go to IDLE on the next edge, with no sample_o, no irq_o, and done_o left at 0.
REQ-030 abort_i SHALL take priority over core_done_i, core_ready_i and the timeout in the same cycle.
REQ-031 start_i outside IDLE SHALL be ignored; n_steps_i changes after latching SHALL have no effect.
REQ-032 busy_o SHALL be high exactly in STEP, WAIT and SAMPLE.
REQ-033 All outputs SHALL be registered or decoded from registered state only; latency from start_i to the first core_start_o SHALL be 1 cycle.
REQ-034 The step counter SHALL NOT wrap: a run ends at n_steps_i, which is at most 2^N_STEPS_W - 1.

Reset
REQ-035 On rst_i the block SHALL enter IDLE with every output 0 and step_cnt_o, the timeout counter and the latched n_steps cleared.
REQ-036 rst_i mid-run SHALL abandon the run with no sample_o or irq_o emitted.

Structure
REQ-037 The state enum spiker_ctrl_state_e and the N_STEPS_W default SHALL reside in spiker_adapter_pkg.
REQ-038 The block SHALL be one module with no sub-module; the timeout counter SHALL be inline, sized by $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-039 Bench SHALL cover: n_steps=3, core_ready=1, done 5 cycles after each start -> 3 core_start handshakes, one sample_o, irq_o 1 cycle, step_cnt_o=3.
REQ-040 Bench SHALL cover: core_ready low for 4 cycles in STEP -> core_start_o held 5 cycles, no WAIT entry before the handshake.
REQ-041 Bench SHALL cover: TIMEOUT_CYCLES=8, no core_done -> err_o=1 and done_o=1 after 8 WAIT cycles, sample_o never asserted.
REQ-042 Bench SHALL cover: abort_i together with core_done_i on the final step -> IDLE, sample_o=0, irq_o=0.
REQ-043 Bench SHALL cover: start with n_steps=0 -> DONE next cycle, irq_o pulse, no core_start_o.
REQ-044 Bench SHALL cover: rst_i in WAIT, then start_i ignored while in DONE, then clear_i -> every output returns to 0, IDLE reached.

Source files
------------

// File: rtl/spiker_adapter_pkg.sv
// Shared types and defaults for the spiker sample controller.
package spiker_adapter_pkg;

    localparam int N_STEPS_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } spiker_ctrl_state_e;

endpackage

// File: rtl/spiker_sample_ctrl_if.sv
// Step handshake between the sample controller (master) and the spiking core (slave).
interface spiker_sample_ctrl_if;

    logic core_start_o;
    logic core_ready_i;
    logic core_done_i;

    modport master (
        output core_start_o,
        input  core_ready_i,
        input  core_done_i
    );

    modport slave (
        input  core_start_o,
        output core_ready_i,
        output core_done_i
    );

endinterface

// File: rtl/spiker_sample_ctrl.sv
// Sequences N core time steps per run, guards each step with a timeout and
// strobes the spike-result writer once the last step completes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_STEP   | core_start_o held until the core accepts (core_ready_i)
// ST_WAIT   | step running; timeout counter advancing until core_done_i
// ST_SAMPLE | one-cycle sample_o strobe after the final step
// ST_DONE   | done_o held, irq_o pulsed on entry; leaves on clear_i
module spiker_sample_ctrl
    import spiker_adapter_pkg::*;
#(
    parameter int N_STEPS_W      = N_STEPS_W_DEF,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 clear_i,
    input  logic [N_STEPS_W-1:0] n_steps_i,
    spiker_sample_ctrl_if.master core,
    output logic                 sample_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 irq_o,
    output logic [N_STEPS_W-1:0] step_cnt_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen during the last permitted WAIT cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    spiker_ctrl_state_e   state_q;
    spiker_ctrl_state_e   state_d;
    logic [N_STEPS_W-1:0] n_steps_q;
    logic [N_STEPS_W-1:0] step_cnt_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic                 err_q;
    logic                 irq_q;
    logic                 last_step;
    logic                 tmo_hit;

    // The counter never wraps: n_steps_q bounds it below the all-ones value.
    assign last_step = (step_cnt_q + N_STEPS_W'(1)) == n_steps_q;
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks done, ready and timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (n_steps_i == '0) ? ST_DONE : ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (core.core_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (core.core_done_i) begin
                    state_d = last_step ? ST_SAMPLE : ST_STEP;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_SAMPLE: begin
                state_d = abort_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run datapath: latched step target, step count, timeout counter, sticky error, irq pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_steps_q  <= '0;
            step_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            // Zero outside WAIT so every step starts with a fresh budget.
            tmo_cnt_q <= (state_q == ST_WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
            irq_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
            if (state_q == ST_IDLE && start_i) begin
                n_steps_q  <= n_steps_i;
                step_cnt_q <= '0;
                err_q      <= 1'b0;
            end
            if (state_q == ST_WAIT && !abort_i) begin
                if (core.core_done_i) begin
                    step_cnt_q <= step_cnt_q + N_STEPS_W'(1);
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        core.core_start_o = (state_q == ST_STEP);
        sample_o          = (state_q == ST_SAMPLE);
        busy_o            = (state_q == ST_STEP) || (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
        done_o            = (state_q == ST_DONE);
        err_o             = err_q;
        irq_o             = irq_q;
        step_cnt_o        = step_cnt_q;
    end

endmodule

// File: tb/tb_spiker_sample_ctrl.sv
// Bench for spiker_sample_ctrl: vector table, directed corner sequences and
// random stimulus compared against a behavioural run model.
module tb_spiker_sample_ctrl;

    localparam int NW  = 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          clear;
    logic [NW-1:0] n_steps;
    logic          sample;
    logic          busy;
    logic          done;
    logic          err;
    logic          irq;
    logic [NW-1:0] step_cnt;

    spiker_sample_ctrl_if bus ();

    spiker_sample_ctrl #(
        .N_STEPS_W     (NW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .abort_i   (abort),
        .clear_i   (clear),
        .n_steps_i (n_steps),
        .core      (bus),
        .sample_o  (sample),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .irq_o     (irq),
        .step_cnt_o(step_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: a run is "requesting", "waiting", "sampling" or "finished".
    bit m_req, m_wait, m_smp, m_done, m_err, m_irq;
    int m_cnt, m_target, m_wcnt;

    task automatic model_step(input bit r, s, a, c, input int n, input bit rdy, dn);
        bit idle;
        idle  = !(m_req || m_wait || m_smp || m_done);
        m_irq = 1'b0;
        if (r) begin
            m_req = 0; m_wait = 0; m_smp = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_target = 0; m_wcnt = 0;
        end else if (idle) begin
            if (s) begin
                m_cnt = 0; m_err = 0; m_target = n;
                if (n == 0) begin
                    m_done = 1; m_irq = 1;
                end else begin
                    m_req = 1;
                end
            end
        end else if (m_done) begin
            if (c) m_done = 0;
        end else if (a) begin
            m_req = 0; m_wait = 0; m_smp = 0;
        end else if (m_req) begin
            if (rdy) begin
                m_req = 0; m_wait = 1; m_wcnt = 0;
            end
        end else if (m_wait) begin
            m_wcnt++;
            if (dn) begin
                m_cnt++;
                m_wait = 0;
                if (m_cnt == m_target) m_smp = 1;
                else m_req = 1;
            end else if (m_wcnt == TMO) begin
                m_wait = 0; m_err = 1; m_done = 1; m_irq = 1;
            end
        end else begin
            m_smp = 0; m_done = 1; m_irq = 1;
        end
    endtask

    task automatic drive_edge(input bit r, s, a, c, input int n, input bit rdy, dn);
        rst              = r;
        start            = s;
        abort            = a;
        clear            = c;
        n_steps          = NW'(n);
        bus.core_ready_i = rdy;
        bus.core_done_i  = dn;
        model_step(r, s, a, c, n, rdy, dn);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".core_start"}, int'(bus.core_start_o), int'(m_req));
        check({tag, ".sample"},     int'(sample),           int'(m_smp));
        check({tag, ".busy"},       int'(busy),             int'(m_req || m_wait || m_smp));
        check({tag, ".done"},       int'(done),             int'(m_done));
        check({tag, ".err"},        int'(err),              int'(m_err));
        check({tag, ".irq"},        int'(irq),              int'(m_irq));
        check({tag, ".step_cnt"},   int'(step_cnt),         m_cnt);
    endtask

    task automatic cyc(input string tag, input bit r, s, a, c, input int n, input bit rdy, dn);
        drive_edge(r, s, a, c, n, rdy, dn);
        compare_model(tag);
    endtask

    typedef struct {
        bit rst, start, abort, clear;
        int n;
        bit ready, cdone;
        bit e_cs, e_smp, e_busy, e_done, e_err, e_irq;
        int e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, s, a, c, input int n, input bit rdy, dn,
                       input bit cs, smp, bsy, dne, er, iq, input int cnt);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.clear = c; v.n = n;
        v.ready = rdy; v.cdone = dn;
        v.e_cs = cs; v.e_smp = smp; v.e_busy = bsy; v.e_done = dne;
        v.e_err = er; v.e_irq = iq; v.e_cnt = cnt;
        tbl.push_back(v);
    endtask

    int hs, smp_cnt, irq_cnt, since, cs_cycles, wait_cycles;
    bit hs_now, dn, fin;

    initial begin
        rst = 1; start = 0; abort = 0; clear = 0; n_steps = '0;
        bus.core_ready_i = 0; bus.core_done_i = 0;

        //   rst s a c n rdy dn | cs smp busy done err irq cnt
        add(1, 0,0,0, 0, 0,0,   0, 0, 0, 0, 0, 0, 0); // reset
        add(0, 1,0,0, 0, 0,0,   0, 0, 0, 1, 0, 1, 0); // zero steps -> DONE + irq
        add(0, 0,0,0, 0, 0,0,   0, 0, 0, 1, 0, 0, 0); // irq only one cycle
        add(0, 1,0,0, 5, 0,0,   0, 0, 0, 1, 0, 0, 0); // start ignored in DONE
        add(0, 0,0,1, 0, 0,0,   0, 0, 0, 0, 0, 0, 0); // clear -> IDLE
        add(0, 1,0,0, 2, 0,0,   1, 0, 1, 0, 0, 0, 0); // start -> STEP after 1 cycle
        add(0, 0,0,0, 7, 0,0,   1, 0, 1, 0, 0, 0, 0); // not ready, holds request
        add(0, 0,0,0, 7, 1,0,   0, 0, 1, 0, 0, 0, 0); // handshake -> WAIT
        add(0, 0,0,0, 7, 0,1,   1, 0, 1, 0, 0, 0, 1); // step 1 done -> STEP
        add(0, 0,0,0, 7, 1,0,   0, 0, 1, 0, 0, 0, 1); // -> WAIT
        add(0, 0,1,0, 7, 0,1,   0, 0, 0, 0, 0, 0, 1); // abort beats final done
        add(0, 0,0,0, 0, 0,0,   0, 0, 0, 0, 0, 0, 1); // stays IDLE, no irq
        add(0, 1,0,0, 1, 0,0,   1, 0, 1, 0, 0, 0, 0); // single-step run
        add(0, 0,0,0, 0, 1,0,   0, 0, 1, 0, 0, 0, 0);
        add(0, 0,0,0, 0, 0,1,   0, 1, 1, 0, 0, 0, 1); // SAMPLE strobe
        add(0, 0,0,0, 0, 0,0,   0, 0, 0, 1, 0, 1, 1); // DONE + irq
        add(0, 0,0,1, 0, 0,0,   0, 0, 0, 0, 0, 0, 1); // clear -> IDLE

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive_edge(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].clear,
                       tbl[i].n, tbl[i].ready, tbl[i].cdone);
            check({t, ".core_start"}, int'(bus.core_start_o), int'(tbl[i].e_cs));
            check({t, ".sample"},     int'(sample),           int'(tbl[i].e_smp));
            check({t, ".busy"},       int'(busy),             int'(tbl[i].e_busy));
            check({t, ".done"},       int'(done),             int'(tbl[i].e_done));
            check({t, ".err"},        int'(err),              int'(tbl[i].e_err));
            check({t, ".irq"},        int'(irq),              int'(tbl[i].e_irq));
            check({t, ".step_cnt"},   int'(step_cnt),         tbl[i].e_cnt);
        end

        // Three steps, core always ready, done 5 cycles after each handshake.
        cyc("three.rst", 1, 0,0,0, 0, 0,0);
        cyc("three.start", 0, 1,0,0, 3, 1,0);
        hs = 0; smp_cnt = 0; irq_cnt = 0; since = -1; fin = 0;
        for (int k = 0; k < 100 && !fin; k++) begin
            hs_now = bus.core_start_o;
            if (since >= 0) since++;
            dn = (since == 5);
            cyc("three.run", 0, 0,0,0, 9, 1, dn);
            if (dn) since = -1;
            if (hs_now) begin
                hs++;
                since = 0;
            end
            smp_cnt += int'(sample);
            irq_cnt += int'(irq);
            fin = done;
        end
        check("three.finished", int'(fin), 1);
        check("three.handshakes", hs, 3);
        check("three.samples", smp_cnt, 1);
        check("three.irqs", irq_cnt, 1);
        check("three.step_cnt", int'(step_cnt), 3);
        cyc("three.after", 0, 0,0,0, 0, 0,0);
        cyc("three.clear", 0, 0,0,1, 0, 0,0);

        // Core not ready for 4 cycles: request must be held 5 cycles in total.
        cyc("hold.start", 0, 1,0,0, 1, 0,0);
        cs_cycles = 0; fin = 0;
        for (int k = 0; k < 20 && !fin; k++) begin
            if (bus.core_start_o) cs_cycles++;
            cyc("hold.step", 0, 0,0,0, 0, (k >= 4), 0);
            fin = busy && !bus.core_start_o;
        end
        check("hold.entered_wait", int'(fin), 1);
        check("hold.core_start_cycles", cs_cycles, 5);
        cyc("hold.done", 0, 0,0,0, 0, 0,1);
        cyc("hold.sample", 0, 0,0,0, 0, 0,0);
        cyc("hold.clear", 0, 0,0,1, 0, 0,0);

        // Timeout after 8 WAIT cycles with no core_done.
        cyc("tmo.start", 0, 1,0,0, 2, 0,0);
        cyc("tmo.hs", 0, 0,0,0, 2, 1,0);
        wait_cycles = 0; smp_cnt = 0; fin = 0;
        for (int k = 0; k < 30 && !fin; k++) begin
            if (busy && !bus.core_start_o) wait_cycles++;
            cyc("tmo.wait", 0, 0,0,0, 0, 0,0);
            smp_cnt += int'(sample);
            fin = done;
        end
        check("tmo.wait_cycles", wait_cycles, TMO);
        check("tmo.err", int'(err), 1);
        check("tmo.done", int'(done), 1);
        check("tmo.samples", smp_cnt, 0);
        cyc("tmo.clear", 0, 0,0,1, 0, 0,0);
        check("tmo.err_after_clear", int'(err), 1);
        check("tmo.done_after_clear", int'(done), 0);
        cyc("tmo.restart", 0, 1,0,0, 1, 0,0);
        check("tmo.err_after_start", int'(err), 0);
        cyc("tmo.abort", 0, 0,1,0, 0, 0,0);

        // Abort coincident with done on the final step.
        cyc("abt.start", 0, 1,0,0, 2, 0,0);
        cyc("abt.hs1", 0, 0,0,0, 0, 1,0);
        cyc("abt.d1", 0, 0,0,0, 0, 0,1);
        cyc("abt.hs2", 0, 0,0,0, 0, 1,0);
        cyc("abt.both", 0, 0,1,0, 0, 0,1);
        check("abt.busy", int'(busy), 0);
        check("abt.sample", int'(sample), 0);
        check("abt.irq", int'(irq), 0);
        check("abt.done", int'(done), 0);
        cyc("abt.after", 0, 0,0,0, 0, 0,0);
        check("abt.irq_after", int'(irq), 0);

        // Reset in WAIT, then ignored start in DONE, then clear.
        cyc("rw.start", 0, 1,0,0, 2, 0,0);
        cyc("rw.hs", 0, 0,0,0, 0, 1,0);
        cyc("rw.rst", 1, 0,0,0, 0, 0,0);
        check("rw.rst_busy", int'(busy), 0);
        check("rw.rst_irq", int'(irq), 0);
        check("rw.rst_sample", int'(sample), 0);
        cyc("rw.zero", 0, 1,0,0, 0, 0,0);
        check("rw.zero_done", int'(done), 1);
        check("rw.zero_irq", int'(irq), 1);
        check("rw.zero_cs", int'(bus.core_start_o), 0);
        cyc("rw.ignored", 0, 1,0,0, 3, 1,0);
        check("rw.ignored_cs", int'(bus.core_start_o), 0);
        check("rw.ignored_busy", int'(busy), 0);
        cyc("rw.clear", 0, 0,0,1, 0, 0,0);
        check("rw.clear_all", int'({bus.core_start_o, sample, busy, done, err, irq}), 0);
        check("rw.clear_cnt", int'(step_cnt), 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc("rand", ($urandom_range(255) == 0), ($urandom_range(7) == 0),
                ($urandom_range(31) == 0), ($urandom_range(3) == 0),
                int'($urandom_range(3)), ($urandom_range(1) == 1), ($urandom_range(3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
